// File: rtl/alien_fleet.sv
// Twelve-alien invader formation: march/descend FSM, alive mask, laser-hit
// detection, score, and the alien pixel layer for the VGA mux.
module alien_fleet #(
    parameter logic [10:0] ORIGIN_X     = 11'd170,
    parameter logic [10:0] ORIGIN_Y     = 11'd100,
    parameter logic [10:0] COL_PITCH    = 11'd50,
    parameter logic [10:0] ROW_PITCH    = 11'd30,
    parameter logic [10:0] ALIEN_LENGTH = 11'd30,
    parameter logic [10:0] ALIEN_HEIGHT = 11'd16,
    parameter logic [10:0] STEP_X       = 11'd10,
    parameter logic [10:0] STEP_Y       = 11'd10,
    parameter logic [5:0]  STEP_FRAMES  = 6'd30,
    parameter logic [5:0]  MIN_FRAMES   = 6'd4,
    parameter logic [10:0] LEFT_EDGE    = 11'd0,
    parameter logic [10:0] RIGHT_EDGE   = 11'd640,
    parameter logic [10:0] LAND_Y       = 11'd400,
    parameter logic [7:0]  COLOR_ALIEN  = 8'b00111111
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         restart,
    input  logic [1:0]   mode,
    input  logic [10:0]  xCoord,
    input  logic [9:0]   yCoord,
    input  logic [10:0]  laser_xCoord,
    input  logic [10:0]  laser_yCoord,
    output logic [131:0] alien_xCoord,
    output logic [131:0] alien_yCoord,
    output logic [11:0]  alive,
    output logic         kill_pulse,
    output logic [13:0]  score,
    output logic         fleet_cleared,
    output logic         fleet_landed,
    output logic [7:0]   rgb,
    output logic         is_alien
);

    localparam logic [11:0] HALF_W    = 12'(ALIEN_LENGTH >> 1);
    localparam logic [11:0] HALF_H    = 12'(ALIEN_HEIGHT >> 1);
    localparam logic [13:0] SCORE_MAX = 14'd9999;

    typedef enum logic [2:0] {
        S_IDLE,
        S_MARCH_R,
        S_MARCH_L,
        S_DESCEND,
        S_CLEARED,
        S_LANDED
    } state_t;

    state_t      state_q, state_d;
    logic        dir_left_q, dir_left_d;
    logic [10:0] ox_q, ox_d;
    logic [10:0] oy_q, oy_d;
    logic [11:0] alive_q, alive_d;
    logic [13:0] score_q, score_d;
    logic [5:0]  frame_cnt_q, frame_cnt_d;
    logic [3:0]  kill_cnt_q, kill_cnt_d;
    logic        cleared_q, cleared_d;
    logic        landed_q, landed_d;
    logic        kill_pulse_q, kill_pulse_d;

    logic [10:0] col_x [6];
    logic [10:0] ax [12];
    logic [10:0] ay [12];
    logic [11:0] hit_vec;
    logic [11:0] pix_vec;
    logic        hit_found;
    logic [3:0]  hit_idx;
    logic [5:0]  col_alive;
    logic [2:0]  rcol, lcol;
    logic        edge_r, edge_l;
    logic [5:0]  dbl_kills, period;
    logic        step_due;
    logic        tick;

    assign tick = (xCoord == 11'd0) && (yCoord == 10'd0);

    // Positions are kept in 11-bit wrapping arithmetic: the origin may go
    // "negative" when only right-hand columns survive a leftward march.
    always_comb begin
        for (int unsigned c = 0; c < 6; c++) begin
            col_x[c] = ox_q + COL_PITCH * 11'(c);
        end
        for (int unsigned r = 0; r < 2; r++) begin
            for (int unsigned c = 0; c < 6; c++) begin
                ax[r*6+c] = col_x[c];
                ay[r*6+c] = oy_q + ROW_PITCH * 11'(r);
            end
        end
    end

    always_comb begin
        hit_vec   = '0;
        pix_vec   = '0;
        hit_found = 1'b0;
        hit_idx   = '0;
        for (int unsigned i = 0; i < 12; i++) begin
            hit_vec[i] = alive_q[i]
                && ({1'b0, laser_xCoord} + HALF_W >= {1'b0, ax[i]})
                && ({1'b0, laser_xCoord} <= {1'b0, ax[i]} + HALF_W)
                && ({1'b0, laser_yCoord} <= {1'b0, ay[i]} + HALF_H + 12'd1)
                && ({1'b0, laser_yCoord} + HALF_H >= {1'b0, ay[i]});
            pix_vec[i] = alive_q[i]
                && ({1'b0, xCoord} + HALF_W >= {1'b0, ax[i]})
                && ({1'b0, xCoord} <= {1'b0, ax[i]} + HALF_W)
                && ({2'b0, yCoord} <= {1'b0, ay[i]} + HALF_H)
                && ({2'b0, yCoord} + HALF_H >= {1'b0, ay[i]});
        end
        for (int unsigned i = 0; i < 12; i++) begin
            if (hit_vec[i] && !hit_found) begin
                hit_found = 1'b1;
                hit_idx   = 4'(i);
            end
        end
    end

    always_comb begin
        col_alive = alive_q[5:0] | alive_q[11:6];
        rcol      = '0;
        lcol      = '0;
        for (int unsigned c = 0; c < 6; c++) begin
            if (col_alive[c]) rcol = 3'(c);
        end
        for (int unsigned c = 6; c > 0; c--) begin
            if (col_alive[c-1]) lcol = 3'(c - 1);
        end
        edge_r = ({1'b0, col_x[rcol]} + HALF_W + {1'b0, STEP_X}) > {1'b0, RIGHT_EDGE};
        edge_l = {1'b0, col_x[lcol]} < ({1'b0, LEFT_EDGE} + {1'b0, STEP_X} + HALF_W);
        dbl_kills = {1'b0, kill_cnt_q, 1'b0};
        period    = (STEP_FRAMES >= MIN_FRAMES + dbl_kills) ? (STEP_FRAMES - dbl_kills)
                                                            : MIN_FRAMES;
        step_due  = frame_cnt_q >= (period - 6'd1);
    end

    always_comb begin
        logic [14:0] score_sum;
        state_d      = state_q;
        dir_left_d   = dir_left_q;
        ox_d         = ox_q;
        oy_d         = oy_q;
        alive_d      = alive_q;
        score_d      = score_q;
        frame_cnt_d  = frame_cnt_q;
        kill_cnt_d   = kill_cnt_q;
        cleared_d    = cleared_q;
        landed_d     = landed_q;
        kill_pulse_d = 1'b0;
        score_sum    = '0;

        if (restart) begin
            state_d     = S_IDLE;
            dir_left_d  = 1'b0;
            ox_d        = ORIGIN_X;
            oy_d        = ORIGIN_Y;
            alive_d     = '1;
            score_d     = '0;
            frame_cnt_d = '0;
            kill_cnt_d  = '0;
            cleared_d   = 1'b0;
            landed_d    = 1'b0;
        end else if (tick) begin
            if (mode != 2'd2) begin
                state_d     = S_IDLE;
                dir_left_d  = 1'b0;
                ox_d        = ORIGIN_X;
                oy_d        = ORIGIN_Y;
                alive_d     = '1;
                frame_cnt_d = '0;
                kill_cnt_d  = '0;
                cleared_d   = 1'b0;
                landed_d    = 1'b0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        state_d    = S_MARCH_R;
                        dir_left_d = 1'b0;
                    end
                    S_MARCH_R, S_MARCH_L, S_DESCEND: begin
                        if (hit_found) begin
                            alive_d[hit_idx] = 1'b0;
                            kill_pulse_d     = 1'b1;
                            kill_cnt_d       = kill_cnt_q + 4'd1;
                            score_sum = {1'b0, score_q} + ((hit_idx < 4'd6) ? 15'd30 : 15'd20);
                            score_d   = (score_sum > {1'b0, SCORE_MAX}) ? SCORE_MAX
                                                                      : score_sum[13:0];
                        end
                        frame_cnt_d = step_due ? 6'd0 : frame_cnt_q + 6'd1;
                        if (step_due) begin
                            case (state_q)
                                S_MARCH_R: begin
                                    if (edge_r) begin
                                        state_d    = S_DESCEND;
                                        dir_left_d = 1'b1;
                                    end else begin
                                        ox_d = ox_q + STEP_X;
                                    end
                                end
                                S_MARCH_L: begin
                                    if (edge_l) begin
                                        state_d    = S_DESCEND;
                                        dir_left_d = 1'b0;
                                    end else begin
                                        ox_d = ox_q - STEP_X;
                                    end
                                end
                                default: begin
                                    oy_d    = oy_q + STEP_Y;
                                    state_d = dir_left_q ? S_MARCH_L : S_MARCH_R;
                                    if (((alive_d[11:6] != '0) &&
                                         ({1'b0, oy_d} + {1'b0, ROW_PITCH} + HALF_H >= {1'b0, LAND_Y})) ||
                                        ((alive_d[5:0] != '0) &&
                                         ({1'b0, oy_d} + HALF_H >= {1'b0, LAND_Y}))) begin
                                        state_d  = S_LANDED;
                                        landed_d = 1'b1;
                                    end
                                end
                            endcase
                        end
                        // The last kill wins over any simultaneous step or landing.
                        if (alive_d == '0) begin
                            state_d   = S_CLEARED;
                            cleared_d = 1'b1;
                            landed_d  = landed_q;
                            ox_d      = ox_q;
                            oy_d      = oy_q;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            dir_left_q   <= 1'b0;
            ox_q         <= ORIGIN_X;
            oy_q         <= ORIGIN_Y;
            alive_q      <= '1;
            score_q      <= '0;
            frame_cnt_q  <= '0;
            kill_cnt_q   <= '0;
            cleared_q    <= 1'b0;
            landed_q     <= 1'b0;
            kill_pulse_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            dir_left_q   <= dir_left_d;
            ox_q         <= ox_d;
            oy_q         <= oy_d;
            alive_q      <= alive_d;
            score_q      <= score_d;
            frame_cnt_q  <= frame_cnt_d;
            kill_cnt_q   <= kill_cnt_d;
            cleared_q    <= cleared_d;
            landed_q     <= landed_d;
            kill_pulse_q <= kill_pulse_d;
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < 12; i++) begin
            alien_xCoord[11*i +: 11] = alive_q[i] ? ax[i] : '0;
            alien_yCoord[11*i +: 11] = alive_q[i] ? ay[i] : '0;
        end
    end

    assign alive         = alive_q;
    assign kill_pulse    = kill_pulse_q;
    assign score         = score_q;
    assign fleet_cleared = cleared_q;
    assign fleet_landed  = landed_q;
    assign is_alien      = |pix_vec;
    assign rgb           = is_alien ? COLOR_ALIEN : '0;

endmodule

// File: tb/tb_alien_fleet.sv
// Directed bench for alien_fleet: reset, marching, edge descent, kills,
// score saturation, clearing, landing and asynchronous reset.
module tb_alien_fleet;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         restart = 1'b0;
    logic [1:0]   mode = 2'd0;
    logic [10:0]  xCoord = 11'd5;
    logic [9:0]   yCoord = 10'd5;
    logic [10:0]  laser_xCoord = 11'd0;
    logic [10:0]  laser_yCoord = 11'd2000;
    logic [131:0] alien_xCoord;
    logic [131:0] alien_yCoord;
    logic [11:0]  alive;
    logic         kill_pulse;
    logic [13:0]  score;
    logic         fleet_cleared;
    logic         fleet_landed;
    logic [7:0]   rgb;
    logic         is_alien;

    int checks = 0;
    int failures = 0;

    alien_fleet dut (
        .clk           (clk),
        .rst           (rst),
        .restart       (restart),
        .mode          (mode),
        .xCoord        (xCoord),
        .yCoord        (yCoord),
        .laser_xCoord  (laser_xCoord),
        .laser_yCoord  (laser_yCoord),
        .alien_xCoord  (alien_xCoord),
        .alien_yCoord  (alien_yCoord),
        .alive         (alive),
        .kill_pulse    (kill_pulse),
        .score         (score),
        .fleet_cleared (fleet_cleared),
        .fleet_landed  (fleet_landed),
        .rgb           (rgb),
        .is_alien      (is_alien)
    );

    always #5 clk = ~clk;

    function automatic logic [10:0] ax(input int i);
        return alien_xCoord[11*i +: 11];
    endfunction

    function automatic logic [10:0] ay(input int i);
        return alien_yCoord[11*i +: 11];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick_only();
        xCoord = 11'd0;
        yCoord = 10'd0;
        @(posedge clk);
        #1;
        xCoord = 11'd5;
        yCoord = 10'd5;
    endtask

    task automatic tick();
        tick_only();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic do_restart();
        restart = 1'b1;
        @(posedge clk);
        #1;
        restart = 1'b0;
    endtask

    task automatic laser_off();
        laser_xCoord = 11'd0;
        laser_yCoord = 11'd2000;
    endtask

    // Starting from a fresh MARCH_R at origin, kill aliens 0..n-1 one per tick.
    // The eleventh tick is also a step (cnt 10 >= period 10 - 1), so alien 11
    // is aimed at with the origin already moved to x=180.
    task automatic kill_wave(input int n);
        for (int i = 0; i < n; i++) begin
            laser_xCoord = 11'(((i == 11) ? 180 : 170) + (i % 6) * 50);
            laser_yCoord = 11'(100 + (i / 6) * 30);
            tick();
        end
        laser_off();
    endtask

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_alive", 32'(alive), 32'hFFF);
        chk("rst_score", 32'(score), 0);
        chk("rst_x0", 32'(ax(0)), 170);
        chk("rst_y0", 32'(ay(0)), 100);
        chk("rst_x11", 32'(ax(11)), 420);
        chk("rst_y11", 32'(ay(11)), 130);
        chk("rst_pulse", 32'(kill_pulse), 0);
        chk("rst_cleared", 32'(fleet_cleared), 0);
        chk("rst_landed", 32'(fleet_landed), 0);
        rst = 1'b1;

        // Pixel layer around alien 0 box (155..185, 92..108)
        xCoord = 11'd170; yCoord = 10'd100; #1;
        chk("pix_center", 32'(is_alien), 1);
        chk("pix_rgb", 32'(rgb), 32'h3F);
        xCoord = 11'd186; #1;
        chk("pix_x_out", 32'(is_alien), 0);
        chk("pix_x_out_rgb", 32'(rgb), 0);
        xCoord = 11'd185; yCoord = 10'd108; #1;
        chk("pix_corner", 32'(is_alien), 1);
        yCoord = 10'd109; #1;
        chk("pix_y_out", 32'(is_alien), 0);
        xCoord = 11'd5; yCoord = 10'd5;

        // Marching right
        mode = 2'd2;
        tick();
        ticks(29);
        chk("march_29", 32'(ax(0)), 170);
        tick();
        chk("march_30", 32'(ax(0)), 180);
        ticks(19 * 30);
        chk("right_edge_x5", 32'(ax(5)), 620);
        ticks(30);
        chk("descend_enter_x5", 32'(ax(5)), 620);
        chk("descend_enter_y5", 32'(ay(5)), 100);
        ticks(30);
        chk("descend_y0", 32'(ay(0)), 110);
        chk("descend_x5", 32'(ax(5)), 620);
        ticks(30);
        chk("march_l_x5", 32'(ax(5)), 610);

        // Single kill, period shortens to 28
        do_restart();
        tick();
        laser_xCoord = 11'd170; laser_yCoord = 11'd108;
        tick_only();
        chk("kill0_pulse", 32'(kill_pulse), 1);
        chk("kill0_alive", 32'(alive), 32'hFFE);
        chk("kill0_score", 32'(score), 30);
        chk("kill0_x", 32'(ax(0)), 0);
        chk("kill0_y", 32'(ay(0)), 0);
        @(posedge clk);
        #1;
        chk("kill0_pulse_end", 32'(kill_pulse), 0);
        laser_off();
        ticks(26);
        chk("period28_before", 32'(ax(1)), 220);
        tick();
        chk("period28_step", 32'(ax(1)), 230);

        // Row 1 kill worth 20; steady laser does not hit again
        do_restart();
        chk("restart_score", 32'(score), 0);
        tick();
        laser_xCoord = 11'd170; laser_yCoord = 11'd135;
        tick_only();
        chk("kill6_pulse", 32'(kill_pulse), 1);
        chk("kill6_alive", 32'(alive), 32'hFBF);
        chk("kill6_score", 32'(score), 20);
        @(posedge clk);
        #1;
        tick();
        chk("kill6_again_alive", 32'(alive), 32'hFBF);
        chk("kill6_again_score", 32'(score), 20);
        laser_off();

        // Clear the whole wave
        do_restart();
        tick();
        kill_wave(12);
        chk("clear_alive", 32'(alive), 0);
        chk("clear_score", 32'(score), 300);
        chk("clear_flag", 32'(fleet_cleared), 1);
        chk("clear_x0", 32'(ax(0)), 0);
        ticks(35);
        chk("clear_hold_flag", 32'(fleet_cleared), 1);
        chk("clear_hold_score", 32'(score), 300);
        chk("clear_hold_alive", 32'(alive), 0);
        chk("clear_hold_landed", 32'(fleet_landed), 0);

        // Leaving play mode reinitialises the formation but keeps the score
        mode = 2'd0;
        tick();
        chk("mode0_alive", 32'(alive), 32'hFFF);
        chk("mode0_score", 32'(score), 300);
        chk("mode0_cleared", 32'(fleet_cleared), 0);
        chk("mode0_x0", 32'(ax(0)), 170);
        mode = 2'd2;
        tick();
        kill_wave(12);
        chk("wave2_score", 32'(score), 600);
        for (int w = 3; w <= 34; w++) begin
            mode = 2'd0;
            tick();
            mode = 2'd2;
            tick();
            kill_wave(12);
            if (w == 33) chk("wave33_score", 32'(score), 9900);
        end
        chk("score_saturate", 32'(score), 9999);

        do_restart();
        chk("restart2_score", 32'(score), 0);
        chk("restart2_alive", 32'(alive), 32'hFFF);
        chk("restart2_cleared", 32'(fleet_cleared), 0);
        chk("restart2_x0", 32'(ax(0)), 170);
        chk("restart2_y0", 32'(ay(0)), 100);

        // Landing with only alien 11 left: lands when its y reaches 400
        tick();
        kill_wave(11);
        chk("land_alive", 32'(alive), 32'h800);
        for (int n = 0; n < 20000 && fleet_landed !== 1'b1; n++) tick();
        chk("landed_flag", 32'(fleet_landed), 1);
        chk("landed_y11", 32'(ay(11)), 400);
        ticks(10);
        chk("landed_hold_y11", 32'(ay(11)), 400);

        // Asynchronous reset between clock edges
        #2;
        rst = 1'b0;
        #1;
        chk("arst_alive", 32'(alive), 32'hFFF);
        chk("arst_x0", 32'(ax(0)), 170);
        chk("arst_y0", 32'(ay(0)), 100);
        chk("arst_landed", 32'(fleet_landed), 0);
        chk("arst_score", 32'(score), 0);
        @(posedge clk);
        #3;
        rst = 1'b1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alien_fleet.md
Name: alien_fleet

Overview:
- Owns the 12-alien invader formation: position, marching/descent state machine, alive mask, laser-hit detection, score.
- Upstream of the spaceship block: drives the packed alien_xCoord/alien_yCoord buses it uses for laser collision.
- Downstream of the spaceship block: consumes current_laser_xCoord/yCoord to decide which alien was hit.
- Also drives the alien pixel layer to the VGA mux.

Parameters:
- ORIGIN_X, 11'd170: initial x centre of alien 0.
- ORIGIN_Y, 11'd100: initial y centre of row 0.
- COL_PITCH, 11'd50: x spacing between columns (6 columns).
- ROW_PITCH, 11'd30: y spacing between rows (2 rows).
- ALIEN_LENGTH, 11'd30: alien width. ALIEN_HEIGHT, 11'd16: alien height.
- STEP_X, 11'd10: horizontal march step. STEP_Y, 11'd10: descent step.
- STEP_FRAMES, 6'd30: frames per step with no kills. MIN_FRAMES, 6'd4: fastest step period.
- LEFT_EDGE, 11'd0 / RIGHT_EDGE, 11'd640: screen limits.
- LAND_Y, 11'd400: alien bottom at or below this means landed.
- COLOR_ALIEN, 8'b00111111: pixel colour.

Ports:
- clk in 1: system clock.
- rst in 1: reset, asynchronous, active-low (asserted at 0).
- restart in 1: synchronous reinitialise.
- mode in 2: game mode; only 2 = play.
- xCoord in 11 / yCoord in 10: current VGA pixel.
- laser_xCoord in 11 / laser_yCoord in 11: spaceship laser centre.
- alien_xCoord out 132: alien i x centre at [11i+10:11i].
- alien_yCoord out 132: alien i y centre, same packing.
- alive out 12: bit i = alien i alive.
- kill_pulse out 1: one clk high on a kill.
- score out 14: accumulated points.
- fleet_cleared out 1 / fleet_landed out 1: end-of-wave flags.
- rgb out 8 / is_alien out 1: pixel layer.

Behaviour:
- Layout: aliens 0-5 are row 0 (y = oy), 6-11 are row 1 (y = oy + ROW_PITCH). x = ox + (i mod 6)*COL_PITCH. Dead aliens read (0,0).
- Frame tick = (xCoord==0 && yCoord==0). All state updates happen only on tick clocks.
- rst low (async) or restart (sync, highest priority): ox/oy = ORIGIN, alive = 12'hFFF, score = 0, state IDLE, frame counter 0, kill count 0, flags 0, kill_pulse 0, rgb 0.
- mode != 2: state IDLE, formation reinitialised except score, which holds.
- mode == 2 in IDLE: go to MARCH_R on the next tick.
- States: IDLE, MARCH_R, MARCH_L, DESCEND, CLEARED, LANDED.
- Step period = max(MIN_FRAMES, STEP_FRAMES - 2*kills). Frame counter increments each tick; at period-1 it is a step tick and the counter clears.
- MARCH_R step:
  - If (rightmost alive column x) + 15 + STEP_X > RIGHT_EDGE: go to DESCEND, dir=L, no move.
  - Else ox += STEP_X.
- MARCH_L step: mirror, using leftmost alive x - 15 < LEFT_EDGE + STEP_X.
- DESCEND step: oy += STEP_Y, then go to MARCH_L or MARCH_R per dir.
  - After the move, if any alive alien has y + 8 >= LAND_Y: go to LANDED, fleet_landed = 1.
- Hit, each tick in the MARCH/DESCEND states:
  - Condition: alive[i] && lx >= ax-15 && lx <= ax+15 && ly <= ay+9 && ly >= ay-8.
  - Lowest index only; at most one kill per tick.
  - Clear alive[i], pulse kill_pulse, score += 30 (row 0) or 20 (row 1), saturating at 9999.
- Hit and step on the same tick: both use pre-tick coordinates and the pre-kill alive mask for edge checks.
- alive becomes 0: go to CLEARED, fleet_cleared = 1, formation frozen.
- CLEARED and LANDED hold until restart, rst, or mode != 2.
- Pixel layer: is_alien = pixel inside any alive alien box (±15 x, ±8 y), combinational. rgb = COLOR_ALIEN when is_alien, else 0.
- Coordinate outputs are registered and change only on tick clocks (one clk after the tick).

Test Plan:
- Reset then mode=2: alien 0 at (170,100), alien 11 at (420,130), alive=FFF. After 30 frames alien 0 at x=180.
- March to the right edge: rightmost x reaches 620, the next step enters DESCEND. The following step gives y 100->110 and MARCH_L.
- Laser at (170,108), alien 0 alive: kill_pulse one clk, alive=FFE, score=30, alien 0 reads (0,0). Step period becomes 28.
- Laser overlapping aliens 0 and 6 on one tick: only alien 0 killed. Alien 6 is killed on the next tick if still overlapping.
- Kill all 12 aliens: score=300, fleet_cleared=1, positions frozen. restart returns to the initial state with score 0.
- Force descents until y+8 >= 400: fleet_landed=1. rst low mid-step asynchronously restores the initial formation.
